// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Clock rate and derived timing constants shared by the stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int DEBOUNCE_2MS = CLK_HZ / 500;
    localparam int HOLD_1S      = CLK_HZ;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchroniser for an asynchronous pin, configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/strtstop_debounce.sv
`default_nettype none
// ============================================================================
// Module   : strtstop_debounce
// Brief    : Start/stop button conditioner: synchronise, debounce, press/release/long pulses.
// Revision : 1.0 - initial release
// ============================================================================
module strtstop_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_2MS,
    parameter int LONG_CYCLES     = HOLD_1S / 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_RAW,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic LEVEL
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HW = $clog2(LONG_CYCLES + 1);

    localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(LONG_CYCLES - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DB_PRESS = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_DB_REL   = 2'd3;

    logic            w_sync;
    logic            w_pressed;
    logic [1:0]      r_state;
    logic [c_DW-1:0] r_dcnt;
    logic [c_HW-1:0] r_hcnt;
    logic            r_long_done;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic            r_level;

    sync2 #(
        .RESET_VAL (ACTIVE_LOW ? 1'b1 : 1'b0)
    ) u_sync2 (
        .clk (CLK),
        .rst (RESET),
        .i_d (BTN_RAW),
        .o_q (w_sync)
    );

    assign w_pressed = w_sync ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= c_IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_long_done <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_level     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pressed) begin
                        r_state <= c_DB_PRESS;
                        r_dcnt  <= '0;
                    end
                end
                c_DB_PRESS: begin
                    if (!w_pressed) begin
                        r_state <= c_IDLE;
                    end else if (r_dcnt == c_DB_LAST) begin
                        r_state     <= c_HELD;
                        r_press     <= 1'b1;
                        r_level     <= 1'b1;
                        r_hcnt      <= '0;
                        r_long_done <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + c_DW'(1);
                    end
                end
                c_HELD: begin
                    if (!w_pressed) begin
                        r_state <= c_DB_REL;
                        r_dcnt  <= '0;
                    end else if (!r_long_done) begin
                        // hcnt freezes at the terminal value once LONG has fired
                        if (r_hcnt == c_HOLD_LAST) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end else begin
                            r_hcnt <= r_hcnt + c_HW'(1);
                        end
                    end
                end
                default: begin
                    if (w_pressed) begin
                        r_state <= c_HELD;
                    end else if (r_dcnt == c_DB_LAST) begin
                        r_state   <= c_IDLE;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + c_DW'(1);
                    end
                end
            endcase
        end
    end

    assign PRESS   = r_press;
    assign RELEASE = r_release;
    assign LONG    = r_long;
    assign LEVEL   = r_level;

endmodule : strtstop_debounce
`default_nettype wire
